// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and digit-serial sizing helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             subEn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, subEn, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, subEn, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/FullAdder.sv
// One-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the MSB for overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    FullAdder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles,
// valid/ready on both sides, registered result with carry/overflow/zero flags.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW         = cnt_width(NUM_DIGITS);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_e           state, next_state;
  logic             load, step, last;
  logic [WIDTH-1:0] op_a, op_b, acc, next_acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, ovf_q, zero_q, in_ready_q, out_valid_q;
  logic [DIGIT-1:0] s_sum;
  logic             s_cout, s_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (op_a[DIGIT-1:0]),
    .y     (op_b[DIGIT-1:0]),
    .cin   (carry),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  assign last     = (cnt == CW'(NUM_DIGITS - 1));
  // Slice sum enters at the top; earlier digits move down toward bit 0.
  assign next_acc = WIDTH'({s_sum, acc} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shifters, accumulator and visible result/flags; result only moves on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
      if (load) begin
        op_a  <= bus.a;
        op_b  <= bus.subEn ? ~bus.b : bus.b;
        carry <= bus.subEn;
        cnt   <= '0;
      end else if (step) begin
        op_a  <= op_a >> DIGIT;
        op_b  <= op_b >> DIGIT;
        acc   <= next_acc;
        carry <= s_cout;
        if (last) begin
          result_q <= next_acc;
          cout_q   <= s_cout;
          ovf_q    <= s_cout ^ s_cmsb;
          zero_q   <= (next_acc == '0);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: DIGIT=8 directed cases, DIGIT=32 and DIGIT=1 random sweeps.
module tb_serial_addsub;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [2:0][W-1:0] a_d, b_d, res;
  logic [2:0]        iv, sub_d, ordy, ir, ov, co, ofl, zr;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(
      .WIDTH (W),
      .DIGIT ((g == 0) ? 8 : (g == 1) ? 32 : 1)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid  = iv[g];
    assign bus.a         = a_d[g];
    assign bus.b         = b_d[g];
    assign bus.subEn     = sub_d[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign res[g]        = bus.result;
    assign co[g]         = bus.cout;
    assign ofl[g]        = bus.overflow;
    assign zr[g]         = bus.zero;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dig(input int k);
    return (k == 0) ? 8 : (k == 1) ? 32 : 1;
  endfunction

  // Full-width golden model of a + (sub ? ~b : b) + sub.
  function automatic exp_t gold(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb    = sv ? ~bv : bv;
    s     = (W+1)'(av) + (W+1)'(bb) + (W+1)'(sv);
    e.r   = s[W-1:0];
    e.c   = s[W];
    e.o   = (av[W-1] == bb[W-1]) && (e.r[W-1] != av[W-1]);
    e.z   = (e.r == '0);
    e.lat = 0;
    return e;
  endfunction

  task automatic do_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input bit hold);
    exp_t e;
    exp_t got_e;
    int   n;
    int   lat;
    e     = gold(av, bv, sv);
    e.lat = W / dig(k);
    sb.push_back(e);
    @(negedge clk);
    a_d[k] = av; b_d[k] = bv; sub_d[k] = sv; iv[k] = 1'b1;
    n = 0;
    while (!ir[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'(1));
    @(posedge clk);
    #1 iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got_e = sb.pop_front();
    chk("latency",  64'(lat),    64'(got_e.lat));
    chk("result",   64'(res[k]), 64'(got_e.r));
    chk("cout",     64'(co[k]),  64'(got_e.c));
    chk("overflow", 64'(ofl[k]), 64'(got_e.o));
    chk("zero",     64'(zr[k]),  64'(got_e.z));
    chk("busy_rdy", 64'(ir[k]),  64'(0));
    if (hold) begin
      // Offer a different op while DONE stalls; it must not be taken.
      a_d[k] = ~av; b_d[k] = av; iv[k] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        chk("hold_res",   64'(res[k]), 64'(got_e.r));
        chk("hold_cout",  64'(co[k]),  64'(got_e.c));
        chk("hold_valid", 64'(ov[k]),  64'(1));
        chk("hold_rdy",   64'(ir[k]),  64'(0));
      end
      iv[k] = 1'b0;
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    #1 ordy[k] = 1'b0;
    chk("drop_valid", 64'(ov[k]),  64'(0));
    chk("idle_rdy",   64'(ir[k]),  64'(1));
    chk("res_kept",   64'(res[k]), 64'(got_e.r));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    iv = '0; sub_d = '0; ordy = '0; a_d = '0; b_d = '0;
    #23;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid",  64'(ov[k]),  64'(0));
      chk("rst_result", 64'(res[k]), 64'(0));
      chk("rst_flags",  64'({co[k], ofl[k], zr[k]}), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("rst_rdy", 64'(ir[k]), 64'(1));

    do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    do_op(0, 32'd5,         32'd7,         1'b1, 1'b0);
    do_op(0, 32'd7,         32'd5,         1'b1, 1'b0);
    do_op(0, 32'h8000_0000, 32'd1,         1'b1, 1'b0);
    do_op(0, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0);
    do_op(0, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);
    do_op(0, 32'h1234_5678, 32'h0101_0101, 1'b0, 1'b1);
    do_op(0, 32'hDEAD_BEEF, 32'h0000_0042, 1'b1, 1'b0);

    // Reset two cycles into RUN: everything clears at once, then the block works again.
    @(negedge clk);
    a_d[0] = 32'h0F0F_0F0F; b_d[0] = 32'h1111_1111; sub_d[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  64'(ov[0]),  64'(0));
    chk("mid_rst_result", 64'(res[0]), 64'(0));
    chk("mid_rst_flags",  64'({co[0], ofl[0], zr[0]}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 64'(ir[0]), 64'(1));
    do_op(0, 32'd3, 32'd4, 1'b0, 1'b0);

    for (int k = 1; k < 3; k++) begin
      do_op(k, 32'hFFFF_FFFF, 32'd1,  1'b0, 1'b0);
      do_op(k, 32'h8000_0000, 32'd1,  1'b1, 1'b0);
      do_op(k, 32'd5,         32'd5,  1'b1, 1'b0);
      for (int i = 0; i < 1000; i++)
        do_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Digit-serial adder/subtractor. Processes DIGIT bits per clock across WIDTH/DIGIT cycles.
- Serves as the area-reduced, multi-cycle successor to the single-cycle ripple-carry adder.
- Used by multi-cycle datapaths (e.g. iterative MUL/DIV steps, low-area ALU config). Accepts operands over a valid/ready handshake.
- Returns a registered result plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32: operand/result width in bits.
- DIGIT, 8: bits added per cycle. WIDTH % DIGIT != 0 is an elaboration error.
- NUM_DIGITS, WIDTH/DIGIT: localparam. Number of compute cycles.

Ports:
- clk  in  1  clock. All state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- subEn  in  1  1 = compute a-b, 0 = compute a+b. Sampled with operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB. For subtract, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release):
  - State goes to IDLE.
  - result, cout, overflow, zero, out_valid go to 0; in_ready goes to 1 after release.
  - Digit counter and operand shift registers clear.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge:
    - opA <= a; opB <= subEn ? ~b : b; carry <= subEn; cnt <= 0.
    - Next state RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - digit slice adds opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
    - opA and opB shift right by DIGIT.
    - result shifts right by DIGIT; the slice sum enters result[WIDTH-1:WIDTH-DIGIT].
    - carry <= slice cout; cnt <= cnt+1.
    - When cnt==NUM_DIGITS-1, also latch:
      - cout <= slice cout.
      - overflow <= slice cout XOR carry-into-slice-MSB.
      - zero <= (final result == 0), including the incoming digit.
    - Next state DONE.
  - DONE: out_valid=1, in_ready=0. Outputs held stable. On out_ready, next state IDLE and out_valid drops the following cycle.
- Latency:
  - out_valid rises exactly NUM_DIGITS cycles after the accepting edge.
  - DIGIT==WIDTH gives 1 cycle; DIGIT==1 gives WIDTH cycles.
- Throughput: one op per NUM_DIGITS+2 cycles minimum (accept, compute, handoff). No overlap of a new accept with DONE.
- in_valid while in_ready=0 is ignored. The producer must hold it; nothing is queued.
- Output hold: result and flags remain at the last value after leaving DONE, until the next op's final RUN edge overwrites them. Only out_valid qualifies them.
- Arithmetic:
  - Modulo 2^WIDTH.
  - overflow is computed from the MSB carries exactly as a full-width two's-complement add of a and (subEn ? ~b : b) with carry-in subEn.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs cleared. No partial result is ever flagged valid.
- cnt width: $clog2(NUM_DIGITS), minimum 1 bit. No wrap beyond NUM_DIGITS-1.

Decomposition:
- Shared package alu_pkg:
  - State encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Helper for NUM_DIGITS and counter width.
- One sub-module: digit_adder.
  - Combinational DIGIT-bit ripple adder.
  - Ports: x, y, cin, sum, cout, c_msb (carry into bit DIGIT-1).
  - Built from the existing FullAdder cell.
- FSM, shift registers and flags live in serial_addsub.

Test Plan (WIDTH=32, DIGIT=8 unless stated):
- Add 0x000000FF+0x00000001 -> result 0x00000100, cout 0, overflow 0, zero 0; out_valid exactly 4 cycles after accept.
- Sub 5-7 -> 0xFFFFFFFE, cout 0, overflow 0. Sub 7-5 -> 0x00000002, cout 1. Sub 0x80000000-1 -> 0x7FFFFFFF, overflow 1.
- Add 0x7FFFFFFF+1 -> 0x80000000, overflow 1, cout 0. Add 0xFFFFFFFF+1 -> 0x00000000, cout 1, zero 1, overflow 0.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready 0, no new accept. Release -> IDLE next cycle, then new op accepted.
- Assert rst_n=0 after 2 RUN cycles -> outputs 0 immediately (async), state IDLE. The next op 3+4 returns 7.
- Parametric sweeps DIGIT=32 and DIGIT=1: 1000 random add/sub ops vs golden model. Check latency 1 and 32 and all flags.
